reg_writeback: RTL

REG_WRITEBACK -- requirements
Module: reg_writeback

---
 rtl/reg_writeback_if.sv | 24 ++
 rtl/reg_writeback.sv | 125 ++++++++++++
 2 files changed

// File: rtl/reg_writeback_if.sv
// Scalar and vector result handshakes into the writeback stage.
// The master offers results and the slave (reg_writeback) grants them.
interface reg_writeback_if;
  logic         s_valid;
  logic [3:0]   s_addr;
  logic [7:0]   s_data;
  logic         s_ready;
  logic         v_valid;
  logic [3:0]   v_addr;
  logic [191:0] v_data;
  logic         v_ready;

  modport master (
    output s_valid, s_addr, s_data,
    output v_valid, v_addr, v_data,
    input  s_ready, v_ready
  );

  modport slave (
    input  s_valid, s_addr, s_data,
    input  v_valid, v_addr, v_data,
    output s_ready, v_ready
  );
endinterface

// File: rtl/reg_writeback.sv
// Writeback stage: round-robin scalar/vector merge into a 4-deep FIFO.
// Define WB_SCOREBOARD_EN to build the per-register pending flags.
module reg_writeback (
  input  logic             clk,
  input  logic             rst,
  reg_writeback_if.slave   wb,
  input  logic             rf_stall,
  output logic             Reg_write,
  output logic [3:0]       A3,
  output logic [191:0]     WD3,
  output logic             desType,
  output logic [5:0]       pend_e,
  output logic [5:0]       pend_v,
  output logic             err_addr
);

  logic         typ_q  [4];
  logic [3:0]   addr_q [4];
  logic [191:0] data_q [4];

  logic [1:0] wptr_q, wptr_d;
  logic [1:0] rptr_q, rptr_d;
  logic [2:0] cnt_q, cnt_d;
  logic       rr_q, rr_d;
  logic       err_q, err_d;

  logic         full, busy, acc, push, pop, contest;
  logic         in_typ;
  logic [3:0]   in_addr;
  logic [191:0] in_data;

  assign full = (cnt_q == 3'd4);
  assign busy = (cnt_q != 3'd0);

  // Ready is forced low in reset so nothing is granted against held state.
  assign wb.s_ready = !rst && !full && wb.s_valid
                      && !(wb.v_valid && rr_q);
  assign wb.v_ready = !rst && !full && wb.v_valid
                      && !(wb.s_valid && !rr_q);

  assign contest = wb.s_valid && wb.v_valid && !full;
  assign acc     = wb.s_ready || wb.v_ready;

  assign in_typ  = wb.v_ready;
  assign in_addr = wb.v_ready ? wb.v_addr : wb.s_addr;
  assign in_data = wb.v_ready ? wb.v_data
                              : {184'd0, wb.s_data};

  assign push = acc && (in_addr <= 4'd5);
  assign pop  = Reg_write;

  assign Reg_write = busy && !rf_stall;
  assign A3        = busy ? addr_q[rptr_q] : 4'd0;
  assign WD3       = busy ? data_q[rptr_q] : 192'd0;
  assign desType   = busy ? typ_q[rptr_q]  : 1'b0;
  assign err_addr  = err_q;

  always_comb begin
    wptr_d = wptr_q;
    rptr_d = rptr_q;
    cnt_d  = cnt_q;
    rr_d   = rr_q;
    err_d  = err_q;
    if (push) wptr_d = wptr_q + 2'd1;
    if (pop)  rptr_d = rptr_q + 2'd1;
    if (push && !pop)      cnt_d = cnt_q + 3'd1;
    else if (!push && pop) cnt_d = cnt_q - 3'd1;
    if (contest) rr_d = !rr_q;
    if (acc && !push) err_d = 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wptr_q <= 2'd0;
      rptr_q <= 2'd0;
      cnt_q  <= 3'd0;
      rr_q   <= 1'b0;
      err_q  <= 1'b0;
    end else begin
      wptr_q <= wptr_d;
      rptr_q <= rptr_d;
      cnt_q  <= cnt_d;
      rr_q   <= rr_d;
      err_q  <= err_d;
    end
  end

  // Payload storage needs no reset; validity is tracked by cnt/pointers.
  always_ff @(posedge clk) begin
    if (push) begin
      typ_q[wptr_q]  <= in_typ;
      addr_q[wptr_q] <= in_addr;
      data_q[wptr_q] <= in_data;
    end
  end

`ifdef WB_SCOREBOARD_EN
  logic [5:0] pe, pv;
  logic [1:0] off;

  always_comb begin
    pe  = 6'd0;
    pv  = 6'd0;
    off = 2'd0;
    for (int i = 0; i < 4; i++) begin
      off = 2'(i) - rptr_q;
      if ({1'b0, off} < cnt_q) begin
        for (int r = 0; r < 6; r++) begin
          if (addr_q[i] == 4'(r)) begin
            if (typ_q[i]) pv[r] = 1'b1;
            else          pe[r] = 1'b1;
          end
        end
      end
    end
  end

  assign pend_e = pe;
  assign pend_v = pv;
`else
  assign pend_e = 6'd0;
  assign pend_v = 6'd0;
`endif

endmodule
